ram_access_arbiter: RTL

//  Sequences typed accesses (byte/half/word/dword) onto the byte-wide 256x8 data RAM.
//  Two requesters share the RAM: port 0 is the data/load-store unit and port 1 is instruction fetch.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/ram_access_arbiter_if.sv | 52 +++++
 rtl/rr_arbiter2.sv | 34 +++
 rtl/ram_access_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the RAM access arbiter: access types, direction
// constants, FSM state encoding and the access-size helper.
package mem_pkg;

    localparam logic [1:0] TYPE_BYTE  = 2'b00;
    localparam logic [1:0] TYPE_HALF  = 2'b01;
    localparam logic [1:0] TYPE_WORD  = 2'b10;
    localparam logic [1:0] TYPE_DWORD = 2'b11;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_XFER  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // Number of RAM byte cycles an access of the given type needs.
    function automatic logic [3:0] byte_count(input logic [1:0] acc_type);
        return 4'd1 << acc_type;
    endfunction

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Bundle of the two requester ports and the byte-wide RAM port.
// slave: the arbiter side; master: requesters plus the RAM model.
interface ram_access_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);

    logic              req0_valid;
    logic              req0_rw;
    logic [1:0]        req0_type;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_done;
    logic [DATA_W-1:0] req0_rdata;

    logic              req1_valid;
    logic              req1_rw;
    logic [1:0]        req1_type;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_done;
    logic [DATA_W-1:0] req1_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;

    logic              busy;

    modport slave (
        input  req0_valid, req0_rw, req0_type, req0_addr, req0_wdata,
        output req0_done, req0_rdata,
        input  req1_valid, req1_rw, req1_type, req1_addr, req1_wdata,
        output req1_done, req1_rdata,
        output ram_en, ram_we, ram_addr, ram_din,
        input  ram_dout,
        output busy
    );

    modport master (
        output req0_valid, req0_rw, req0_type, req0_addr, req0_wdata,
        input  req0_done, req0_rdata,
        output req1_valid, req1_rw, req1_type, req1_addr, req1_wdata,
        input  req1_done, req1_rdata,
        input  ram_en, ram_we, ram_addr, ram_din,
        output ram_dout,
        input  busy
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. A lone requester always wins; on contention
// the port that did not win the previous contention is granted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic       grant
);

    logic last_grant;

    // Select the granted port from the current requests.
    always_comb begin
        // NOTE: default assigned first so every path drives grant and no latch is inferred.
        grant = 1'b0;
        if (valid == 2'b11) begin
            grant = ~last_grant;
        end else if (valid[1]) begin
            grant = 1'b1;
        end
    end

    // Remember the winner of each contended grant; port 0 wins the first one.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            last_grant <= 1'b1;
        end else if (advance && valid == 2'b11) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Sequences byte/half/word/dword accesses from two requesters onto a
// byte-wide RAM, big-endian, assembling read bytes into a right-justified
// result and pulsing done for the granted requester.
module ram_access_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    ram_access_arbiter_if.slave bus
);

    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = $clog2(BYTES);

    state_t            state;
    state_t            state_nxt;

    logic              rw_q;
    logic [1:0]        type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              gid_q;
    logic [CNT_W-1:0]  cnt;
    logic              rd_pend;
    logic [DATA_W-1:0] acc;

    logic [1:0]        valid_vec;
    logic              any_valid;
    logic              advance;
    logic              grant_id;
    logic              xfer;
    logic              last_byte;
    logic [3:0]        nbytes;
    logic [CNT_W-1:0]  widx;
    logic [7:0]        wbyte;

    assign valid_vec = {bus.req1_valid, bus.req0_valid};
    assign any_valid = |valid_vec;
    assign advance   = (state == ST_IDLE);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid   (valid_vec),
        .advance (advance),
        .grant   (grant_id)
    );

    // Byte k of the access goes to addr+k and carries wdata byte N-1-k.
    assign nbytes    = byte_count(type_q);
    assign last_byte = (4'(cnt) == nbytes - 4'd1);
    assign widx      = CNT_W'(nbytes - 4'd1 - 4'(cnt));
    assign wbyte     = wdata_q[{widx, 3'b000} +: 8];

    // Next-state logic: grant in IDLE, N byte cycles, one drain cycle, one response cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (any_valid) state_nxt = ST_XFER;
            ST_XFER:  if (last_byte) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the granted request, step the byte counter and shift in read bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            rw_q    <= RD;
            type_q  <= TYPE_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            gid_q   <= 1'b0;
            cnt     <= '0;
            rd_pend <= 1'b0;
            acc     <= '0;
        end else begin
            // The RAM returns a read byte one cycle after its address cycle.
            rd_pend <= xfer && (rw_q == RD);
            if (state == ST_IDLE && any_valid) begin
                gid_q   <= grant_id;
                rw_q    <= grant_id ? bus.req1_rw    : bus.req0_rw;
                type_q  <= grant_id ? bus.req1_type  : bus.req0_type;
                addr_q  <= grant_id ? bus.req1_addr  : bus.req0_addr;
                wdata_q <= grant_id ? bus.req1_wdata : bus.req0_wdata;
                cnt     <= '0;
                acc     <= '0;
            end else begin
                if (xfer) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (rd_pend) begin
                    acc <= {acc[DATA_W-9:0], bus.ram_dout};
                end
            end
        end
    end

    assign xfer         = (state == ST_XFER);
    assign bus.ram_en   = xfer;
    assign bus.ram_we   = xfer && (rw_q == WR);
    assign bus.ram_addr = xfer ? addr_q + ADDR_W'(cnt) : '0;
    assign bus.ram_din  = (xfer && rw_q == WR) ? wbyte : 8'h00;
    assign bus.busy     = (state != ST_IDLE);

    assign bus.req0_done  = (state == ST_RESP) && !gid_q;
    assign bus.req1_done  = (state == ST_RESP) &&  gid_q;
    assign bus.req0_rdata = bus.req0_done ? acc : '0;
    assign bus.req1_rdata = bus.req1_done ? acc : '0;

endmodule
